// File: rtl/rave_cache_pkg.sv
// Shared definitions for the tag store: controller state encoding and the
// default geometry used by both the tag store and the data store.
package rave_cache_pkg;

    localparam int unsigned DEF_SETS  = 4;
    localparam int unsigned DEF_WAYS  = 4;
    localparam int unsigned DEF_TAG_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/lru_age_update.sv
// Recency-age update for one set. The touched way moves to age 0 and every
// way that was more recent than it ages by one. Ages remain a permutation.
module lru_age_update #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned AGE_W = 2
)(
    input  logic [WAYS*AGE_W-1:0] i_ages,
    input  logic [WAYS-1:0]       i_touch,
    input  logic                  i_en,
    output logic [WAYS*AGE_W-1:0] o_ages
);

    logic [AGE_W-1:0] w_touch_age;

    // Select the old age of the touched way, then re-rank the set.
    always_comb begin
        w_touch_age = '0;
        o_ages      = i_ages;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (i_touch[w]) begin
                w_touch_age = w_touch_age | i_ages[w*AGE_W +: AGE_W];
            end
        end
        if (i_en) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (i_touch[w]) begin
                    o_ages[w*AGE_W +: AGE_W] = '0;
                end else if (i_ages[w*AGE_W +: AGE_W] < w_touch_age) begin
                    o_ages[w*AGE_W +: AGE_W] = i_ages[w*AGE_W +: AGE_W] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tag_store_lru.sv
// Set-associative tag store with true-LRU replacement and a sequential
// flush engine that invalidates one set per cycle.
module tag_store_lru
    import rave_cache_pkg::*;
#(
    parameter  int unsigned SETS  = DEF_SETS,
    parameter  int unsigned WAYS  = DEF_WAYS,
    parameter  int unsigned TAG_W = DEF_TAG_W,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned AGE_W = $clog2(WAYS)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_v,
    input  logic                  fill_v,
    input  logic [IDX_W-1:0]      index,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  flush_req,
    output logic                  rsp_v,
    output logic [WAYS-1:0]       hit,
    output logic                  hit_any,
    output logic [WAYS-1:0]       victim_way,
    output logic                  victim_valid,
    output logic [TAG_W-1:0]      victim_tag,
    output logic [WAYS*TAG_W-1:0] tag_dump,
    output logic                  busy
);

    // Per-set storage, ways packed side by side (way i at [i*W +: W]).
    logic [WAYS-1:0]       r_valid [SETS];
    logic [WAYS*TAG_W-1:0] r_tag   [SETS];
    logic [WAYS*AGE_W-1:0] r_age   [SETS];

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_W-1:0]      r_flush_idx;

    logic                  r_rsp_v;
    logic [WAYS-1:0]       r_hit;
    logic                  r_hit_any;
    logic [WAYS-1:0]       r_victim_way;
    logic                  r_victim_valid;
    logic [TAG_W-1:0]      r_victim_tag;
    logic [WAYS*TAG_W-1:0] r_tag_dump;

    logic                  w_idle;
    logic                  w_lookup_acc;
    logic                  w_fill_acc;
    logic [WAYS-1:0]       w_set_valid;
    logic [WAYS*TAG_W-1:0] w_set_tags;
    logic [WAYS*AGE_W-1:0] w_set_ages;
    logic [WAYS-1:0]       w_hit;
    logic [WAYS-1:0]       w_victim;
    logic [WAYS-1:0]       w_rsp_victim;
    logic                  w_rsp_vvalid;
    logic [TAG_W-1:0]      w_rsp_vtag;
    logic [WAYS*TAG_W-1:0] w_fill_tags;
    logic [WAYS-1:0]       w_touch;
    logic                  w_age_en;
    logic [WAYS*AGE_W-1:0] w_new_ages;

    // Ages after reset or flush: age equals way number.
    function automatic logic [WAYS*AGE_W-1:0] f_init_ages();
        logic [WAYS*AGE_W-1:0] a;
        a = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            a[w*AGE_W +: AGE_W] = AGE_W'(w);
        end
        return a;
    endfunction

    // Lowest-numbered invalid way, otherwise the least recently used way.
    function automatic logic [WAYS-1:0] f_victim(input logic [WAYS-1:0]       v,
                                                 input logic [WAYS*AGE_W-1:0] a);
        logic [WAYS-1:0] sel;
        logic            found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!v[w] && !found) begin
                sel[w] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (a[w*AGE_W +: AGE_W] == AGE_W'(WAYS-1)) begin
                    sel[w] = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    // Request qualification: flush wins over fill, fill wins over lookup.
    assign w_idle       = (r_state == IDLE);
    assign w_fill_acc   = w_idle && !flush_req && fill_v;
    assign w_lookup_acc = w_idle && !flush_req && lookup_v && !fill_v;

    assign w_set_valid  = r_valid[index];
    assign w_set_tags   = r_tag[index];
    assign w_set_ages   = r_age[index];

    // Tag compare of the addressed set against the incoming tag.
    always_comb begin
        w_hit = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_hit[w] = w_set_valid[w] && (w_set_tags[w*TAG_W +: TAG_W] == tag_in);
        end
    end

    assign w_victim = f_victim(w_set_valid, w_set_ages);

    // Fill writes the tag into the victim way only.
    always_comb begin
        w_fill_tags = w_set_tags;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w_victim[w]) begin
                w_fill_tags[w*TAG_W +: TAG_W] = tag_in;
            end
        end
    end

    // Fill and lookup never both commit, so one age updater serves both.
    assign w_touch  = w_fill_acc ? w_victim : w_hit;
    assign w_age_en = w_fill_acc || (w_lookup_acc && (|w_hit));

    lru_age_update #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_age (
        .i_ages  (w_set_ages),
        .i_touch (w_touch),
        .i_en    (w_age_en),
        .o_ages  (w_new_ages)
    );

    // The response reports the victim as it stands after this lookup's update.
    assign w_rsp_victim = f_victim(w_set_valid, w_new_ages);

    // One-hot mux of the reported victim's valid bit and tag.
    always_comb begin
        w_rsp_vvalid = 1'b0;
        w_rsp_vtag   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w_rsp_victim[w]) begin
                w_rsp_vvalid = w_rsp_vvalid | w_set_valid[w];
                w_rsp_vtag   = w_rsp_vtag | w_set_tags[w*TAG_W +: TAG_W];
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start flush from IDLE, leave after the last set is cleared.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (flush_req) w_state_next = FLUSH;
            FLUSH:   if (r_flush_idx == IDX_W'(SETS-1)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Array updates: flush sweep, fill allocation, or lookup-hit aging.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_tag[s]   <= '0;
                r_age[s]   <= f_init_ages();
            end
            r_flush_idx <= '0;
        end else if (r_state == FLUSH) begin
            r_valid[r_flush_idx] <= '0;
            r_age[r_flush_idx]   <= f_init_ages();
            r_flush_idx          <= r_flush_idx + IDX_W'(1);
        end else begin
            r_flush_idx <= '0;
            if (w_fill_acc) begin
                r_valid[index] <= w_set_valid | w_victim;
                r_tag[index]   <= w_fill_tags;
                r_age[index]   <= w_new_ages;
            end else if (w_lookup_acc) begin
                r_age[index]   <= w_new_ages;
            end
        end
    end

    // Registered lookup response; hit is forced low when no lookup was taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_v        <= 1'b0;
            r_hit          <= '0;
            r_hit_any      <= 1'b0;
            r_victim_way   <= '0;
            r_victim_valid <= 1'b0;
            r_victim_tag   <= '0;
            r_tag_dump     <= '0;
        end else begin
            r_rsp_v   <= w_lookup_acc;
            r_hit     <= w_lookup_acc ? w_hit : '0;
            r_hit_any <= w_lookup_acc && (|w_hit);
            if (w_lookup_acc) begin
                r_victim_way   <= w_rsp_victim;
                r_victim_valid <= w_rsp_vvalid;
                r_victim_tag   <= w_rsp_vtag;
                r_tag_dump     <= w_set_tags;
            end
        end
    end

    assign rsp_v        = r_rsp_v;
    assign hit          = r_hit;
    assign hit_any      = r_hit_any;
    assign victim_way   = r_victim_way;
    assign victim_valid = r_victim_valid;
    assign victim_tag   = r_victim_tag;
    assign tag_dump     = r_tag_dump;
    assign busy         = (r_state == FLUSH);

endmodule

// File: tb/tb_tag_store_lru.sv
// Directed bench for tag_store_lru with SETS=4, WAYS=4, TAG_W=8.
module tb_tag_store_lru;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_v;
    logic        fill_v;
    logic [1:0]  index;
    logic [7:0]  tag_in;
    logic        flush_req;
    logic        rsp_v;
    logic [3:0]  hit;
    logic        hit_any;
    logic [3:0]  victim_way;
    logic        victim_valid;
    logic [7:0]  victim_tag;
    logic [31:0] tag_dump;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    tag_store_lru #(
        .SETS  (4),
        .WAYS  (4),
        .TAG_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_v     (lookup_v),
        .fill_v       (fill_v),
        .index        (index),
        .tag_in       (tag_in),
        .flush_req    (flush_req),
        .rsp_v        (rsp_v),
        .hit          (hit),
        .hit_any      (hit_any),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_tag   (victim_tag),
        .tag_dump     (tag_dump),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        lv;
        logic        fv;
        logic [1:0]  idx;
        logic [7:0]  tag;
        logic        e_rsp;
        logic [3:0]  e_hit;
        logic        ck_vic;
        logic [3:0]  e_vic;
        logic        e_vv;
        logic [7:0]  e_vt;
        logic        ck_dump;
        logic [31:0] e_dump;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic lv, input logic fv,
                                input logic [1:0] idx, input logic [7:0] tag,
                                input logic e_rsp, input logic [3:0] e_hit,
                                input logic ck_vic, input logic [3:0] e_vic,
                                input logic e_vv, input logic [7:0] e_vt,
                                input logic ck_dump, input logic [31:0] e_dump);
        vec_t v;
        v.name = nm; v.lv = lv; v.fv = fv; v.idx = idx; v.tag = tag;
        v.e_rsp = e_rsp; v.e_hit = e_hit; v.ck_vic = ck_vic; v.e_vic = e_vic;
        v.e_vv = e_vv; v.e_vt = e_vt; v.ck_dump = ck_dump; v.e_dump = e_dump;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic fv, input logic fr,
                         input logic [1:0] idx, input logic [7:0] tag);
        lookup_v  = lv;
        fill_v    = fv;
        flush_req = fr;
        index     = idx;
        tag_in    = tag;
    endtask

    // Lookup miss on an invalidated set: rsp, no hit, victim way 0 invalid.
    task automatic chk_miss_empty(input string nm, input logic [1:0] idx, input logic [7:0] tag);
        drive(1'b1, 1'b0, 1'b0, idx, tag);
        tick();
        chk({nm, "_rsp"},  32'(rsp_v), 32'd1);
        chk({nm, "_hit"},  32'({hit_any, hit}), 32'h0);
        chk({nm, "_vic"},  32'({victim_valid, victim_way}), 32'h01);
    endtask

    vec_t vecs[21];

    initial begin
        int cnt;

        vecs[0]  = mk("miss_empty",  1,0,2'd1,8'h3C, 1,4'b0000, 1,4'b0001,0,8'h00, 0,32'h0);
        vecs[1]  = mk("fill2_a0",    0,1,2'd2,8'hA0, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[2]  = mk("fill2_a1",    0,1,2'd2,8'hA1, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[3]  = mk("fill2_a2",    0,1,2'd2,8'hA2, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[4]  = mk("fill2_a3",    0,1,2'd2,8'hA3, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[5]  = mk("hit2_a0",     1,0,2'd2,8'hA0, 1,4'b0001, 0,4'b0000,0,8'h00, 1,32'hA3A2A1A0);
        vecs[6]  = mk("hit2_a2_lru1",1,0,2'd2,8'hA2, 1,4'b0100, 1,4'b0010,1,8'hA1, 0,32'h0);
        vecs[7]  = mk("miss2_77",    1,0,2'd2,8'h77, 1,4'b0000, 1,4'b0010,1,8'hA1, 0,32'h0);
        vecs[8]  = mk("miss1_a0",    1,0,2'd1,8'hA0, 1,4'b0000, 1,4'b0001,0,8'h00, 0,32'h0);
        vecs[9]  = mk("fill0_10",    0,1,2'd0,8'h10, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[10] = mk("fill0_11",    0,1,2'd0,8'h11, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[11] = mk("fill0_12",    0,1,2'd0,8'h12, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[12] = mk("fill0_13",    0,1,2'd0,8'h13, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[13] = mk("miss0_full",  1,0,2'd0,8'h99, 1,4'b0000, 1,4'b0001,1,8'h10, 0,32'h0);
        vecs[14] = mk("fill0_55",    0,1,2'd0,8'h55, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[15] = mk("hit0_55",     1,0,2'd0,8'h55, 1,4'b0001, 1,4'b0010,1,8'h11, 1,32'h13121155);
        vecs[16] = mk("miss0_10",    1,0,2'd0,8'h10, 1,4'b0000, 1,4'b0010,1,8'h11, 0,32'h0);
        vecs[17] = mk("hit0_13",     1,0,2'd0,8'h13, 1,4'b1000, 1,4'b0010,1,8'h11, 0,32'h0);
        vecs[18] = mk("fill_lkp3",   1,1,2'd3,8'hC3, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);
        vecs[19] = mk("hit3_c3",     1,0,2'd3,8'hC3, 1,4'b0001, 1,4'b0010,0,8'h00, 1,32'h000000C3);
        vecs[20] = mk("idle",        0,0,2'd0,8'h00, 0,4'b0000, 0,4'b0000,0,8'h00, 0,32'h0);

        // Reset with every request asserted: reset must win.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
        tick();
        tick();
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_rsp",   32'(rsp_v), 32'd0);
        chk("reset_hit",   32'({hit_any, hit}), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();

        // Table-driven functional vectors, one request per cycle.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].lv, vecs[i].fv, 1'b0, vecs[i].idx, vecs[i].tag);
            tick();
            chk({vecs[i].name, "_rsp"},  32'(rsp_v), 32'(vecs[i].e_rsp));
            chk({vecs[i].name, "_hit"},  32'(hit), 32'(vecs[i].e_hit));
            chk({vecs[i].name, "_hany"}, 32'(hit_any), 32'(|vecs[i].e_hit));
            chk({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
            if (vecs[i].ck_vic) begin
                chk({vecs[i].name, "_vway"}, 32'(victim_way), 32'(vecs[i].e_vic));
                chk({vecs[i].name, "_vval"}, 32'(victim_valid), 32'(vecs[i].e_vv));
                chk({vecs[i].name, "_vtag"}, 32'(victim_tag), 32'(vecs[i].e_vt));
            end
            if (vecs[i].ck_dump) begin
                chk({vecs[i].name, "_dump"}, tag_dump, vecs[i].e_dump);
            end
        end

        // Flush with a same-cycle lookup: flush wins, then lookups and repeated
        // flush requests are ignored while busy.
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'hA0);
        tick();
        chk("flush_start_busy", 32'(busy), 32'd1);
        chk("flush_start_rsp",  32'(rsp_v), 32'd0);
        cnt = 1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("flush_rsp_low", 32'(rsp_v), 32'd0);
            if (busy) cnt++;
        end
        chk("flush_busy_cycles", 32'(cnt), 32'd4);
        chk("flush_done", 32'(busy), 32'd0);
        chk_miss_empty("post_flush_2a0", 2'd2, 8'hA0);
        chk_miss_empty("post_flush_055", 2'd0, 8'h55);
        chk_miss_empty("post_flush_3c3", 2'd3, 8'hC3);
        chk_miss_empty("post_flush_013", 2'd0, 8'h13);

        // Reset in the second flush cycle aborts the flush.
        drive(1'b0, 1'b1, 1'b0, 2'd3, 8'h33);
        tick();
        drive(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
        tick();
        chk("rflush_busy1", 32'(busy), 32'd1);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'd3, 8'h44);
        tick();
        rst_n = 1'b1;
        chk("rflush_busy_after_rst", 32'(busy), 32'd0);
        chk("rflush_rsp_after_rst",  32'(rsp_v), 32'd0);
        chk("rflush_hit_after_rst",  32'({hit_any, hit}), 32'h0);
        chk_miss_empty("rflush_3_33", 2'd3, 8'h33);
        chk_miss_empty("rflush_3_44", 2'd3, 8'h44);

        // A fresh flush request is accepted and completes in bounded time.
        drive(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
        tick();
        flush_req = 1'b0;
        chk("reflush_busy", 32'(busy), 32'd1);
        cnt = 1;
        for (int k = 0; k < 8 && busy; k++) begin
            tick();
            if (busy) cnt++;
        end
        chk("reflush_cycles", 32'(cnt), 32'd4);
        chk("reflush_idle",   32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
